// File: rtl/vram_dbuf.sv
// Double-buffered 128x128 pixel store: tracer fills the back buffer in raster order, VGA reads the front.
// Buffers swap on the vs falling edge once the back buffer is complete; the display never sees a partial frame.
module vram_dbuf #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 12
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sof,
  output logic              wr_frame_done,
  input  logic [ADDR_W-1:0] rd_col,
  input  logic [ADDR_W-1:0] rd_row,
  output logic [DATA_W-1:0] rd_data,
  input  logic              vs,
  output logic              front_sel,
  output logic              swap_pending
);

  localparam int DEPTH = 1 << (2 * ADDR_W + 1);

  typedef enum logic {FILL, WAIT_SWAP} state_t;

  state_t              state_q, state_d;
  logic                front_q, front_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic                done_q, done_d;
  logic                vs_q;
  logic [DATA_W-1:0]   rd_q;

  logic                accept;
  logic                swap;
  logic [ADDR_W-1:0]   col_eff, row_eff;
  logic [2*ADDR_W:0]   wr_addr, rd_addr;

  // Front/back select is the MSB of a single RAM.
  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_ready      = (state_q == FILL);
  assign accept        = wr_valid & wr_ready;
  assign swap          = (state_q == WAIT_SWAP) & vs_q & ~vs;
  assign col_eff       = wr_sof ? '0 : col_q;
  assign row_eff       = wr_sof ? '0 : row_q;
  assign wr_addr       = {~front_q, row_eff, col_eff};
  assign rd_addr       = {front_q, rd_row, rd_col};
  assign wr_frame_done = done_q;
  assign rd_data       = rd_q;
  assign front_sel     = front_q;
  assign swap_pending  = (state_q == WAIT_SWAP);

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (wr_sof) begin
            // Resync: this pixel is (0,0), the next one goes to column 1 of row 0.
            col_d = 1;
            row_d = '0;
          end else begin
            col_d = col_q + 1'b1;
            if (col_q == '1) begin
              row_d = row_q + 1'b1;
            end
            if ((col_q == '1) && (row_q == '1)) begin
              state_d = WAIT_SWAP;
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (swap) begin
          front_d = ~front_q;
          col_d   = '0;
          row_d   = '0;
          done_d  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= FILL;
      front_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      vs_q    <= vs;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read uses the registered front_q, so a same-cycle swap still reads the old front buffer.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule
